backtrack_unit: RTL

//  Conflict-recovery stage directly downstream of the trace stack in the DPLL solver.
//  On a conflict it pops trace entries and un-assigns each forced (F) variable.
//  At the most recent decision (D) it un-assigns the variable, writes the complementary value, and pushes it back as forced.
//  If the stack empties before a decision is found, it reports UNSAT.

---
 rtl/backtrack_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/backtrack_unit.sv
// Conflict-recovery stage: pops the trace stack, un-assigns forced variables,
// flips the most recent decision and pushes it back as forced, or reports UNSAT.
module backtrack_unit #(
    parameter int NUM_VARIABLE = 128,
    parameter int VAR_IDX_W    = 9,
    localparam int CNT_W       = $clog2(NUM_VARIABLE + 2)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 trace_pop,
    output logic                 trace_push,
    output logic                 trace_type,
    output logic                 trace_val,
    output logic [VAR_IDX_W-1:0] trace_var,
    input  logic                 trace_done,
    input  logic                 trace_empty,
    input  logic                 trace_type_in,
    input  logic                 trace_val_in,
    input  logic [VAR_IDX_W-1:0] trace_var_in,
    output logic                 asg_we,
    output logic [VAR_IDX_W-1:0] asg_var,
    output logic                 asg_assigned,
    output logic                 asg_val,
    output logic                 busy,
    output logic                 done,
    output logic                 unsat,
    output logic [VAR_IDX_W-1:0] flip_var,
    output logic                 flip_val,
    output logic [CNT_W-1:0]     pop_count
);

    typedef enum logic [2:0] {
        IDLE,
        POP_REQ,
        POP_WAIT,
        CLEAR,
        FLIP,
        PUSH_REQ,
        PUSH_WAIT,
        FINISH
    } state_t;

    state_t                 state;
    logic                   popped_type;
    logic                   popped_val;
    logic [VAR_IDX_W-1:0]   popped_var;

    // Outputs are registered for the state being entered, so each strobe is
    // high exactly while the FSM sits in the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            popped_type  <= 1'b0;
            popped_val   <= 1'b0;
            popped_var   <= '0;
            trace_pop    <= 1'b0;
            trace_push   <= 1'b0;
            trace_type   <= 1'b0;
            trace_val    <= 1'b0;
            trace_var    <= '0;
            asg_we       <= 1'b0;
            asg_var      <= '0;
            asg_assigned <= 1'b0;
            asg_val      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            unsat        <= 1'b0;
            flip_var     <= '0;
            flip_val     <= 1'b0;
            pop_count    <= '0;
        end else begin
            trace_pop  <= 1'b0;
            trace_push <= 1'b0;
            asg_we     <= 1'b0;
            done       <= 1'b0;
            unsat      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= POP_REQ;
                        trace_pop <= 1'b1;
                        busy      <= 1'b1;
                        pop_count <= '0;
                    end
                end

                POP_REQ: begin
                    state <= POP_WAIT;
                end

                POP_WAIT: begin
                    if (trace_done) begin
                        popped_type <= trace_type_in;
                        popped_val  <= trace_val_in;
                        popped_var  <= trace_var_in;
                        if (trace_empty) begin
                            state <= FINISH;
                            unsat <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state        <= CLEAR;
                            asg_we       <= 1'b1;
                            asg_var      <= trace_var_in;
                            asg_assigned <= 1'b0;
                            if (pop_count != '1) begin
                                pop_count <= pop_count + 1'b1;
                            end
                        end
                    end
                end

                // Forced entries loop straight back to another pop; a decision
                // is rewritten with its complement.
                CLEAR: begin
                    if (popped_type) begin
                        state     <= POP_REQ;
                        trace_pop <= 1'b1;
                    end else begin
                        state        <= FLIP;
                        asg_we       <= 1'b1;
                        asg_var      <= popped_var;
                        asg_assigned <= 1'b1;
                        asg_val      <= ~popped_val;
                        flip_var     <= popped_var;
                        flip_val     <= ~popped_val;
                    end
                end

                FLIP: begin
                    state      <= PUSH_REQ;
                    trace_push <= 1'b1;
                    trace_type <= 1'b1;
                    trace_val  <= flip_val;
                    trace_var  <= flip_var;
                end

                PUSH_REQ: begin
                    state <= PUSH_WAIT;
                end

                PUSH_WAIT: begin
                    if (trace_done) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
